// File: rtl/control_pkg.sv
// control_pkg: shared state, instruction-class, opcode-pattern and field encodings for the LEGv8 controllers
package control_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;
  typedef enum logic [3:0] {
    C_ILL, C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI, C_MOVZ, C_B, C_CBZ, C_LDUR, C_STUR
  } cls_t;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ORR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MOV = 4'b0111;
  localparam logic [2:0] SE_IMM = 3'b000;
  localparam logic [2:0] SE_MEM = 3'b001;
  localparam logic [2:0] SE_BR  = 3'b010;
  localparam logic [2:0] SE_CB  = 3'b011;
  typedef struct packed {
    logic       reg2loc;
    logic       alusrc;
    logic [3:0] aluop;
    logic [2:0] signop;
  } fields_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: opcode to instruction class and datapath fields (MULTICYCLE_CTRL_CBNZ_EN widens CBZ to CBZ/CBNZ)
module control_decode
  import control_pkg::*;
(
  input  logic [10:0] i_opcode,
  output cls_t        o_cls,
  output fields_t     o_fld
);
  logic w_cb;
`ifdef MULTICYCLE_CTRL_CBNZ_EN
  assign w_cb = i_opcode[10:4] == OP_CBZ[7:1];
`else
  assign w_cb = i_opcode[10:3] == OP_CBZ;
`endif
  // classify the opcode, then derive the fields; unused fields stay 0
  always_comb begin
    o_cls = (i_opcode == OP_AND) ? C_AND :
            (i_opcode == OP_ORR) ? C_ORR :
            (i_opcode == OP_ADD) ? C_ADD :
            (i_opcode == OP_SUB) ? C_SUB :
            (i_opcode[10:1] == OP_ADDI) ? C_ADDI :
            (i_opcode[10:1] == OP_SUBI) ? C_SUBI :
            (i_opcode[10:2] == OP_MOVZ) ? C_MOVZ :
            (i_opcode[10:5] == OP_B) ? C_B :
            w_cb ? C_CBZ :
            (i_opcode == OP_LDUR) ? C_LDUR :
            (i_opcode == OP_STUR) ? C_STUR : C_ILL;
    o_fld.aluop = (o_cls == C_ORR) ? ALU_ORR :
                  (o_cls inside {C_ADD, C_ADDI, C_LDUR, C_STUR}) ? ALU_ADD :
                  (o_cls inside {C_SUB, C_SUBI}) ? ALU_SUB :
                  (o_cls == C_MOVZ) ? ALU_MOV : ALU_AND;
    o_fld.signop = (o_cls == C_MOVZ) ? i_opcode[2:0] :
                   (o_cls inside {C_LDUR, C_STUR}) ? SE_MEM :
                   (o_cls == C_B) ? SE_BR :
                   (o_cls == C_CBZ) ? SE_CB : SE_IMM;
    o_fld.alusrc = o_cls inside {C_ADDI, C_SUBI, C_MOVZ, C_LDUR, C_STUR};
    o_fld.reg2loc = o_cls inside {C_CBZ, C_STUR};
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: LEGv8 multi-cycle FSM with memory watchdog (MULTICYCLE_CTRL_CBNZ_EN enables CBNZ)
module multicycle_control
  import control_pkg::*;
#(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255,
  parameter int ALUOP_W  = 4
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [10:0]        opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               imem_req,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               pcsrc,
  output logic               reg2loc,
  output logic               alusrc,
  output logic               mem2reg,
  output logic               regwrite,
  output logic               memread,
  output logic               memwrite,
  output logic               branch,
  output logic               uncond_branch,
  output logic [ALUOP_W-1:0] aluop,
  output logic [2:0]         signop,
  output logic [2:0]         state,
  output logic               busy,
  output logic               fault
);
  state_t            r_state, w_next;
  cls_t              r_cls, w_cls;
  fields_t           r_fld, w_fld;
  logic              r_inv;
  logic [WAIT_W-1:0] r_cnt;
  logic              w_pend, w_to, w_fv;
  control_decode u_dec (.i_opcode(opcode), .o_cls(w_cls), .o_fld(w_fld));
  assign w_pend = r_state == S_FETCH || r_state == S_MEM;
  assign w_to = r_cnt == WAIT_W'(MAX_WAIT);
  assign w_fv = r_state inside {S_EXEC, S_MEM, S_WB};
  assign alusrc = w_fv & r_fld.alusrc;
  assign reg2loc = w_fv & r_fld.reg2loc;
  assign aluop = w_fv ? ALUOP_W'(r_fld.aluop) : '0;
  assign signop = w_fv ? r_fld.signop : 3'd0;
  assign state = r_state;
  assign fault = r_state == S_FAULT;
  assign busy = ~fault;
  // state register
  always_ff @(posedge CLK or negedge resetl)
    if (!resetl) r_state <= S_FETCH;
    else r_state <= w_next;
  // capture the decoded class and fields at the end of DECODE
  always_ff @(posedge CLK or negedge resetl)
    if (!resetl) begin
      r_cls <= C_ILL;
      r_fld <= '0;
      r_inv <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_cls <= w_cls;
      r_fld <= w_fld;
`ifdef MULTICYCLE_CTRL_CBNZ_EN
      r_inv <= opcode[3];
`else
      r_inv <= 1'b0;
`endif
    end
  // watchdog: cleared on state entry, saturating count while a request is pending
  always_ff @(posedge CLK or negedge resetl)
    if (!resetl) r_cnt <= '0;
    else r_cnt <= (w_next != r_state) ? '0 : (w_pend && r_cnt != '1) ? r_cnt + WAIT_W'(1) : r_cnt;
  // next state and per-phase strobes; a same-cycle ack beats the timeout
  always_comb begin
    w_next = r_state;
    imem_req = 1'b0;
    irwrite = 1'b0;
    pcwrite = 1'b0;
    pcsrc = 1'b0;
    regwrite = 1'b0;
    memread = 1'b0;
    memwrite = 1'b0;
    mem2reg = 1'b0;
    branch = 1'b0;
    uncond_branch = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = resetl;
        irwrite = resetl & mem_ready;
        w_next = mem_ready ? S_DECODE : w_to ? S_FAULT : S_FETCH;
      end
      S_DECODE: w_next = (w_cls == C_ILL) ? S_FAULT : S_EXEC;
      S_EXEC: begin
        uncond_branch = r_cls == C_B;
        branch = r_cls == C_CBZ;
        pcwrite = uncond_branch | branch;
        pcsrc = uncond_branch | (branch & (zero ^ r_inv));
        w_next = pcwrite ? S_FETCH : (r_cls inside {C_LDUR, C_STUR}) ? S_MEM : S_WB;
      end
      S_MEM: begin
        memread = r_cls == C_LDUR;
        memwrite = ~memread;
        pcwrite = memwrite & mem_ready;
        w_next = mem_ready ? (memread ? S_WB : S_FETCH) : w_to ? S_FAULT : S_MEM;
      end
      S_WB: begin
        regwrite = 1'b1;
        mem2reg = r_cls == C_LDUR;
        pcwrite = 1'b1;
        w_next = S_FETCH;
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction streams checked against a per-instruction trace model
module tb_multicycle_control;
  localparam int MAXW = 255;
  localparam logic [23:0] RST = 24'h000100;
  logic CLK = 1'b0, resetl = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [10:0] opcode = 11'd0;
  logic imem_req, irwrite, pcwrite, pcsrc, reg2loc, alusrc, mem2reg, regwrite;
  logic memread, memwrite, branch, uncond_branch, busy, fault;
  logic [3:0] aluop;
  logic [2:0] signop, state;
  logic [23:0] obs;
  int n_chk = 0, n_pass = 0;
  logic [23:0] q_exp[$];
  bit q_rdy[$];
  string g_tag;
  bit g_fault;
  logic [10:0] t_pat[13], t_msk[13];
  logic [3:0] m_aluop;
  logic [2:0] m_signop;
  bit m_alusrc, m_reg2loc;
  multicycle_control #(.WAIT_W(8), .MAX_WAIT(MAXW), .ALUOP_W(4)) dut (
    .CLK(CLK), .resetl(resetl), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .imem_req(imem_req), .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
    .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .branch(branch), .uncond_branch(uncond_branch),
    .aluop(aluop), .signop(signop), .state(state), .busy(busy), .fault(fault)
  );
  assign obs = {state, imem_req, irwrite, pcwrite, pcsrc, regwrite, memread, memwrite, mem2reg,
                branch, uncond_branch, alusrc, reg2loc, busy, fault, aluop, signop};
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask
  function automatic bit rnd();
    return bit'($urandom_range(1, 0));
  endfunction
  function automatic int cls_of(input logic [10:0] op);
    for (int i = 1; i <= 12; i++) begin
`ifndef MULTICYCLE_CTRL_CBNZ_EN
      if (i == 12) continue;
`endif
      if ((op & t_msk[i]) == t_pat[i]) return i;
    end
    return 0;
  endfunction
  task automatic fields(input int c, input logic [10:0] op);
    m_aluop = (c == 2) ? 4'd1 : (c inside {3, 5, 10, 11}) ? 4'd2 : (c inside {4, 6}) ? 4'd6 : (c == 7) ? 4'd7 : 4'd0;
    m_signop = (c == 7) ? op[2:0] : (c inside {10, 11}) ? 3'd1 : (c == 8) ? 3'd2 : (c inside {9, 12}) ? 3'd3 : 3'd0;
    m_alusrc = c inside {5, 6, 7, 10, 11};
    m_reg2loc = c inside {9, 11, 12};
  endtask
  task automatic push(input logic [2:0] st, input logic [9:0] s, input bit fv, input bit rdy);
    q_exp.push_back({st, s, fv & m_alusrc, fv & m_reg2loc, st != 3'd5, st == 3'd5,
                     fv ? m_aluop : 4'd0, fv ? m_signop : 3'd0});
    q_rdy.push_back(rdy);
  endtask
  task automatic req(input logic [2:0] st, input logic [9:0] s, input logic [9:0] s_ack,
                     input bit fv, input int w, output bit to);
    to = w > MAXW;
    for (int i = 0; i < (to ? MAXW + 1 : w); i++) push(st, s, fv, 1'b0);
    if (!to) push(st, s_ack, fv, 1'b1);
  endtask
  task automatic flt();
    for (int i = 0; i < 21; i++) push(3'd5, 10'd0, 1'b0, rnd());
    g_fault = 1'b1;
  endtask
  task automatic build(input logic [10:0] op, input bit z, input int fw, input int mw);
    int c = cls_of(op);
    bit to;
    fields(c, op);
    g_fault = 1'b0;
    req(3'd0, 10'b1000000000, 10'b1100000000, 1'b0, fw, to);
    if (to) begin flt(); return; end
    push(3'd1, 10'd0, 1'b0, rnd());
    if (c == 0) begin flt(); return; end
    if (c == 8) push(3'd2, 10'b0011000001, 1'b1, rnd());
    else if (c == 9 || c == 12) push(3'd2, {3'b001, (c == 9) ? z : !z, 4'b0000, 2'b10}, 1'b1, rnd());
    else begin
      push(3'd2, 10'd0, 1'b1, rnd());
      if (c == 10) begin
        req(3'd3, 10'b0000010000, 10'b0000010000, 1'b1, mw, to);
        if (to) begin flt(); return; end
        push(3'd4, 10'b0010100100, 1'b1, rnd());
      end else if (c == 11) begin
        req(3'd3, 10'b0000001000, 10'b0010001000, 1'b1, mw, to);
        if (to) begin flt(); return; end
      end else push(3'd4, 10'b0010100000, 1'b1, rnd());
    end
  endtask
  task automatic play(input int n);
    int k = 0;
    logic [23:0] e;
    while (q_exp.size() != 0 && (n < 0 || k < n)) begin
      mem_ready = q_rdy.pop_front();
      e = q_exp.pop_front();
      #1 chk($sformatf("%s@%0d", g_tag, k), obs, e);
      @(posedge CLK);
      #1 k++;
    end
    q_exp.delete();
    q_rdy.delete();
  endtask
  task automatic do_rst();
    resetl = 1'b0;
    #1 chk({g_tag, "/rst"}, obs, RST);
    @(posedge CLK);
    #1 resetl = 1'b1;
  endtask
  task automatic run(input string tag, input logic [10:0] op, input bit z, input int fw, input int mw);
    g_tag = tag;
    opcode = op;
    zero = z;
    build(op, z, fw, mw);
    play(-1);
    if (g_fault) do_rst();
  endtask
  initial begin
    t_pat[0] = 11'd0;            t_msk[0] = 11'd0;
    t_pat[1] = 11'b10001010000;  t_msk[1] = 11'h7ff;
    t_pat[2] = 11'b10101010000;  t_msk[2] = 11'h7ff;
    t_pat[3] = 11'b10001011000;  t_msk[3] = 11'h7ff;
    t_pat[4] = 11'b11001011000;  t_msk[4] = 11'h7ff;
    t_pat[5] = 11'b10010001000;  t_msk[5] = 11'h7fe;
    t_pat[6] = 11'b11010001000;  t_msk[6] = 11'h7fe;
    t_pat[7] = 11'b11010010100;  t_msk[7] = 11'h7fc;
    t_pat[8] = 11'b00010100000;  t_msk[8] = 11'h7e0;
    t_pat[9] = 11'b10110100000;  t_msk[9] = 11'h7f8;
    t_pat[10] = 11'b11111000010; t_msk[10] = 11'h7ff;
    t_pat[11] = 11'b11111000000; t_msk[11] = 11'h7ff;
    t_pat[12] = 11'b10110101000; t_msk[12] = 11'h7f8;
    repeat (2) @(posedge CLK);
    #1 chk("reset", obs, RST);
    @(posedge CLK);
    #1 resetl = 1'b1;
    run("addreg", 11'b10001011000, 1'b0, 0, 0);
    run("ldur", 11'b11111000010, 1'b0, 0, 3);
    run("cbz_z1", 11'b10110100000, 1'b1, 0, 0);
    run("cbz_z0", 11'b10110100000, 1'b0, 0, 0);
    run("stur", 11'b11111000000, 1'b0, 1, 2);
    run("movz", 11'b11010010111, 1'b0, 0, 0);
    run("illegal", 11'd0, 1'b0, 0, 0);
    run("fetch_to", 11'b10001011000, 1'b0, MAXW + 1, 0);
    run("fetch_ack", 11'b10001011000, 1'b0, MAXW, 0);
    run("mem_to", 11'b11111000010, 1'b0, 0, MAXW + 1);
    run("cbnz", 11'b10110101000, 1'b0, 0, 0);
    g_tag = "midrst";
    opcode = 11'b10001011000;
    build(opcode, 1'b0, 0, 0);
    play(3);
    do_rst();
    for (int i = 0; i < 150; i++) begin
      int c = $urandom_range(12, 0);
      logic [10:0] op = (c == 0) ? 11'($urandom) : (t_pat[c] | (11'($urandom) & ~t_msk[c]));
      run($sformatf("rnd%0d", i), op, rnd(), $urandom_range(3, 0), $urandom_range(3, 0));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
